// File: rtl/apb_master_mux.sv
// APB master with a valid/ready command port, slave-index decode on the upper
// address bits, per-slave PREADY/PRDATA/PSLVERR muxing and wait-state timeout.
module apb_master_mux #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [SEL_WIDTH+ADDR_WIDTH-1:0]  req_addr,
  input  logic                             req_write,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_strb,
  input  logic [2:0]                       req_prot,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SEL_WIDTH:0] NUM_SEL = (SEL_WIDTH + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                  state;
  logic [SEL_WIDTH-1:0]    sel_idx;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    err_pend;

  logic [SEL_WIDTH-1:0]    req_idx;
  logic                    req_idx_ok;
  logic [NUM_SLAVES-1:0]   req_onehot;
  logic                    pready_sel;
  logic                    pslverr_sel;
  logic [DATA_WIDTH-1:0]   prdata_sel;
  logic                    accept;
  logic                    complete;
  logic                    timeout_hit;

  assign req_idx    = req_addr[SEL_WIDTH+ADDR_WIDTH-1 -: SEL_WIDTH];
  assign req_idx_ok = ({1'b0, req_idx} < NUM_SEL);

  always_comb begin
    req_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (req_idx == SEL_WIDTH'(i)) req_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == SEL_WIDTH'(i)) begin
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
        prdata_sel  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A decode error accepted in a completing ACCESS cycle has its response
  // deferred one cycle (err_pend), so IDLE refuses commands while it drains.
  assign complete    = (state == ACCESS) && pready_sel;
  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !pready_sel
                       && (wait_cnt == CNT_LAST);
  assign req_ready   = ((state == IDLE) && !err_pend) || complete;
  assign accept      = req_valid && req_ready;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      sel_idx     <= '0;
      wait_cnt    <= '0;
      err_pend    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;

      if (err_pend) begin
        err_pend  <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end

      case (state)
        IDLE: ;
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready_sel) begin
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr_sel;
            rsp_rdata <= (!PWRITE && !pslverr_sel) ? prdata_sel : '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // A new command overrides the end-of-transfer bus values assigned above.
      if (accept) begin
        if (req_idx_ok) begin
          state    <= SETUP;
          sel_idx  <= req_idx;
          wait_cnt <= '0;
          PSEL     <= req_onehot;
          PENABLE  <= 1'b0;
          PWRITE   <= req_write;
          PADDR    <= req_addr[ADDR_WIDTH-1:0];
          PWDATA   <= req_wdata;
          PSTRB    <= req_write ? req_strb : '0;
          PPROT    <= req_prot;
        end else if (state == IDLE) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else begin
          err_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench: per-cycle vector table on a 4-slave/TIMEOUT=16 instance, plus
// hand sequences for reset, decode error and unbounded wait on a 3-slave/TIMEOUT=0 one.
module tb_apb_master_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req_valid, req_valid2, req_write;
  logic [9:0]   req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_strb;
  logic [2:0]   req_prot;
  logic [3:0]   pready, pslverr;
  logic [127:0] prdata;

  logic         a_rdy, a_rv, a_rerr, a_rto, a_pen, a_pwrite;
  logic [31:0]  a_rdata, a_pwdata;
  logic [3:0]   a_psel, a_pstrb;
  logic [7:0]   a_paddr;
  logic [2:0]   a_pprot;

  logic         b_rdy, b_rv, b_rerr, b_rto, b_pen, b_pwrite;
  logic [31:0]  b_rdata, b_pwdata;
  logic [2:0]   b_psel;
  logic [3:0]   b_pstrb;
  logic [7:0]   b_paddr;
  logic [2:0]   b_pprot;

  apb_master_mux #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_WIDTH(2), .TIMEOUT(16)) u_dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_ready(a_rdy), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_rerr), .rsp_timeout(a_rto),
    .PSEL(a_psel), .PENABLE(a_pen), .PWRITE(a_pwrite), .PADDR(a_paddr), .PWDATA(a_pwdata),
    .PSTRB(a_pstrb), .PPROT(a_pprot),
    .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
  );

  apb_master_mux #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_SLAVES(3), .SEL_WIDTH(2), .TIMEOUT(0)) u_dut2 (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid2), .req_ready(b_rdy), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_rerr), .rsp_timeout(b_rto),
    .PSEL(b_psel), .PENABLE(b_pen), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
    .PSTRB(b_pstrb), .PPROT(b_pprot),
    .PREADY(pready[2:0]), .PRDATA(prdata[95:0]), .PSLVERR(pslverr[2:0])
  );

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [3:0]  ready;
    logic [3:0]  slverr;
  } in_t;

  typedef struct packed {
    logic        rdy;
    logic [3:0]  psel;
    logic        pen;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic        rv;
    logic        rerr;
    logic        rto;
    logic [31:0] rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input in_t i, input out_t o);
    vecs.push_back({i, o});
  endtask

  task automatic drive(input in_t i);
    req_valid = i.valid;
    req_write = i.write;
    req_addr  = i.addr;
    req_wdata = i.wdata;
    req_strb  = i.strb;
    req_prot  = i.prot;
    pready    = i.ready;
    pslverr   = i.slverr;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    out_t act;
    int   cnt;

    prdata     = {32'h33333333, 32'h22222222, 32'h12345678, 32'hA5A50000};
    req_valid2 = 1'b0;
    drive('0);

    // out: {rdy, psel, pen, pwrite, paddr, pstrb, pprot, pwdata, rv, rerr, rto, rdata}
    // Reset state
    add('0, {1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    // Write slave 2, zero wait
    add({1'b1, 1'b1, 10'h210, 32'hDEADBEEF, 4'hF, 3'd2, 4'b0100, 4'b0000},
        {1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b0100, 4'b0000},
        {1'b0, 4'b0100, 1'b0, 1'b1, 8'h10, 4'hF, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b0100, 4'b0000},
        {1'b1, 4'b0100, 1'b1, 1'b1, 8'h10, 4'hF, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b0100, 4'b0000},
        {1'b1, 4'b0000, 1'b0, 1'b1, 8'h10, 4'hF, 3'd2, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0});
    add('0, {1'b1, 4'b0000, 1'b0, 1'b1, 8'h10, 4'hF, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0});
    // Read slave 1, three wait states, other slaves ready (ignored)
    add({1'b1, 1'b0, 10'h144, 32'h0, 4'hF, 3'd5, 4'b0000, 4'b0000},
        {1'b1, 4'b0000, 1'b0, 1'b1, 8'h10, 4'hF, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b1101, 4'b0000},
        {1'b0, 4'b0010, 1'b0, 1'b0, 8'h44, 4'h0, 3'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    for (int k = 0; k < 3; k++)
      add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b1101, 4'b0000},
          {1'b0, 4'b0010, 1'b1, 1'b0, 8'h44, 4'h0, 3'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b0010, 4'b0000},
        {1'b1, 4'b0010, 1'b1, 1'b0, 8'h44, 4'h0, 3'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add('0, {1'b1, 4'b0000, 1'b0, 1'b0, 8'h44, 4'h0, 3'd5, 32'h0, 1'b1, 1'b0, 1'b0, 32'h12345678});
    // Back-to-back: write slave 0, then read slave 3 accepted in the completing cycle
    add({1'b1, 1'b1, 10'h001, 32'h11111111, 4'h3, 3'd0, 4'b1111, 4'b0000},
        {1'b1, 4'b0000, 1'b0, 1'b0, 8'h44, 4'h0, 3'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF, 3'd7, 4'b1111, 4'b0000},
        {1'b0, 4'b0001, 1'b0, 1'b1, 8'h01, 4'h3, 3'd0, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF, 3'd7, 4'b1111, 4'b0000},
        {1'b1, 4'b0001, 1'b1, 1'b1, 8'h01, 4'h3, 3'd0, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b1111, 4'b0000},
        {1'b0, 4'b1000, 1'b0, 1'b0, 8'hFF, 4'h0, 3'd7, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b1111, 4'b0000},
        {1'b1, 4'b1000, 1'b1, 1'b0, 8'hFF, 4'h0, 3'd7, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add('0, {1'b1, 4'b0000, 1'b0, 1'b0, 8'hFF, 4'h0, 3'd7, 32'h0, 1'b1, 1'b0, 1'b0, 32'h33333333});
    // Write slave 0 with PSLVERR; other slaves' PSLVERR ignored
    add({1'b1, 1'b1, 10'h020, 32'h0BADF00D, 4'hF, 3'd1, 4'b0000, 4'b1110},
        {1'b1, 4'b0000, 1'b0, 1'b0, 8'hFF, 4'h0, 3'd7, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b0000, 4'b1110},
        {1'b0, 4'b0001, 1'b0, 1'b1, 8'h20, 4'hF, 3'd1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b0001, 4'b0001},
        {1'b1, 4'b0001, 1'b1, 1'b1, 8'h20, 4'hF, 3'd1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 32'h0});
    add('0, {1'b1, 4'b0000, 1'b0, 1'b1, 8'h20, 4'hF, 3'd1, 32'h0BADF00D, 1'b1, 1'b1, 1'b0, 32'h0});
    // Timeout: read slave 2, PREADY[2] never rises; abort after 16 ACCESS cycles
    add({1'b1, 1'b0, 10'h2AA, 32'h0, 4'hF, 3'd6, 4'b0000, 4'b0000},
        {1'b1, 4'b0000, 1'b0, 1'b1, 8'h20, 4'hF, 3'd1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b1011, 4'b0000},
        {1'b0, 4'b0100, 1'b0, 1'b0, 8'hAA, 4'h0, 3'd6, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    for (int k = 0; k < 15; k++)
      add({1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 3'd0, 4'b1011, 4'b0000},
          {1'b0, 4'b0100, 1'b1, 1'b0, 8'hAA, 4'h0, 3'd6, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add({1'b1, 1'b1, 10'h001, 32'h11111111, 4'h3, 3'd0, 4'b1011, 4'b0000},
        {1'b0, 4'b0100, 1'b1, 1'b0, 8'hAA, 4'h0, 3'd6, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    add('0, {1'b1, 4'b0000, 1'b0, 1'b0, 8'hAA, 4'h0, 3'd6, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0});
    add('0, {1'b1, 4'b0000, 1'b0, 1'b0, 8'hAA, 4'h0, 3'd6, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});

    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      #1;
      act = {a_rdy, a_psel, a_pen, a_pwrite, a_paddr, a_pstrb, a_pprot, a_pwdata,
             a_rv, a_rerr, a_rto, a_rdata};
      chk($sformatf("vec%0d", k), 128'(act), 128'(vecs[k].o));
    end

    // Reset asserted in the middle of ACCESS
    @(negedge clk);
    drive({1'b1, 1'b0, 10'h155, 32'h0, 4'h0, 3'd0, 4'b0000, 4'b0000});
    @(negedge clk);
    drive('0);
    @(negedge clk);
    #1 chk("rst_pre_access", 128'({a_psel, a_pen}), 128'({4'b0010, 1'b1}));
    #1 rst = 1'b1;
    #1 chk("rst_async_drop", 128'({a_rdy, a_psel, a_pen, a_rv}), 128'({1'b1, 4'b0000, 1'b0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      #1 if (a_rv || a_pen || (a_psel != 4'b0000)) cnt++;
    end
    chk("rst_no_rsp", 128'(cnt), 128'(0));

    // Decode error on 3-slave instance (index 3)
    @(negedge clk);
    drive({1'b0, 1'b1, 10'h305, 32'h55AA55AA, 4'hF, 3'd0, 4'b0000, 4'b0000});
    req_valid2 = 1'b1;
    #1 chk("dec_accept", 128'({b_rdy, b_psel}), 128'({1'b1, 3'b000}));
    @(negedge clk);
    req_valid2 = 1'b0;
    #1 chk("dec_rsp", 128'({b_rv, b_rerr, b_rto, b_rdata, b_psel, b_pen}),
           128'({1'b1, 1'b1, 1'b0, 32'h0, 3'b000, 1'b0}));
    @(negedge clk);
    #1 chk("dec_rsp_once", 128'({b_rv, b_rdy}), 128'({1'b0, 1'b1}));

    // TIMEOUT=0: ACCESS holds indefinitely, then completes when PREADY[1] rises
    @(negedge clk);
    drive({1'b0, 1'b0, 10'h108, 32'h0, 4'hF, 3'd3, 4'b0000, 4'b0000});
    req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1 if (b_pen && (b_psel == 3'b010) && !b_rv && !b_rdy) cnt++;
    end
    chk("no_timeout_hold", 128'(cnt), 128'(40));
    @(negedge clk);
    pready = 4'b0010;
    #1 chk("no_timeout_ready", 128'(b_rdy), 128'(1));
    @(negedge clk);
    pready = 4'b0000;
    #1 chk("no_timeout_rsp", 128'({b_rv, b_rerr, b_rto, b_rdata, b_pen}),
           128'({1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
